// File: rtl/mcif_write_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcif_write_pkg
// Description : Shared sizing constants and helpers for the MCIF write
//               ingress path (command length width, outstanding-beat counter
//               width, length FIFO depth, len-to-beats conversion).
// Revision    : 1.0 - initial release
// ============================================================================
package mcif_write_pkg;

    // Command length is encoded as beats-1.
    localparam int LEN_W       = 2;
    // Outstanding-beat counter; must hold 256 (limit register 255 + 1).
    localparam int OS_CNT_W    = 9;
    // Accepted commands whose data has not yet fully left (power of 2).
    localparam int LFIFO_DEPTH = 4;

    // Beat count of a command, one bit wider than the counter so that
    // credit sums never wrap.
    function automatic logic [OS_CNT_W:0] beats(input logic [LEN_W-1:0] len);
        return (OS_CNT_W+1)'(len) + (OS_CNT_W+1)'(1);
    endfunction

endpackage : mcif_write_pkg
`default_nettype wire

// File: rtl/mcif_write_len_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mcif_write_len_fifo
// Description : Small flop-based FIFO with registered full/empty flags.
//               Holds command lengths so the data side knows where each
//               burst ends.
// Ports       : clk, rst_n  - clock, async active-low reset
//               push_i/data_i - write strobe and data (ignored when full)
//               pop_i         - read strobe (ignored when empty)
//               head_o        - oldest entry
//               full_o/empty_o- registered status flags
// Revision    : 1.0 - initial release
// ============================================================================
module mcif_write_len_fifo
    import mcif_write_pkg::*;
#(
    parameter int WIDTH = LEN_W,
    parameter int DEPTH = LFIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT1   = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR1   = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             w_push, w_pop;

    assign w_push  = push_i & ~full_q;
    assign w_pop   = pop_i & ~empty_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - C_CNT1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + C_PTR1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + C_PTR1;
            count_q <= count_d;
            full_q  <= (count_d == C_FULL);
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : mcif_write_len_fifo
`default_nettype wire

// File: rtl/mcif_write_os_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mcif_write_os_ctrl
// Description : Outstanding-write controller. Admits write commands only
//               while the outstanding-beat budget allows, frees budget on
//               egress returns, and releases W beats only after their command
//               has been accepted, generating wlast from the command length.
// Ports       : nvdla_core_clk/rstn      - clock, async active-low reset
//               reg2dp_wr_os_cnt         - outstanding-beat limit minus 1
//               cmd_in_* / cmd_out_*     - command path to AW converter
//               dat_in_* / dat_out_*     - data beat path to W converter
//               eg2ig_axi_vld/len        - completed command returns
//               os_cnt_cur, os_err       - status (counter, sticky underflow)
// Revision    : 1.0 - initial release
// ============================================================================
module mcif_write_os_ctrl
    import mcif_write_pkg::*;
(
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic [7:0]          reg2dp_wr_os_cnt,
    input  logic                cmd_in_valid,
    output logic                cmd_in_ready,
    input  logic [LEN_W-1:0]    cmd_in_len,
    output logic                cmd_out_valid,
    input  logic                cmd_out_ready,
    input  logic                dat_in_valid,
    output logic                dat_in_ready,
    output logic                dat_out_valid,
    input  logic                dat_out_ready,
    output logic                dat_out_last,
    input  logic                eg2ig_axi_vld,
    input  logic [LEN_W-1:0]    eg2ig_axi_len,
    output logic [OS_CNT_W-1:0] os_cnt_cur,
    output logic                os_err
);

    logic [OS_CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic                os_err_q, os_err_d;
    logic                aw_hold_q, aw_hold_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic [OS_CNT_W:0]   w_limit, w_need, w_sum, w_ret;
    logic                w_credit_ok, w_aw_hs, w_dat_hs, w_pop;
    logic [LEN_W-1:0]    w_head;
    logic                w_full, w_empty;

    // ---------------- command side ----------------
    assign w_limit     = (OS_CNT_W+1)'(reg2dp_wr_os_cnt) + (OS_CNT_W+1)'(1);
    assign w_need      = {1'b0, os_cnt_q} + beats(cmd_in_len);
    assign w_credit_ok = (w_need <= w_limit);

    // Once AW valid has been shown it stays up until taken, regardless of a
    // limit change or the FIFO status.
    assign cmd_out_valid = cmd_in_valid & ((w_credit_ok & ~w_full) | aw_hold_q);
    assign cmd_in_ready  = cmd_out_ready & cmd_out_valid;
    assign w_aw_hs       = cmd_in_ready;

    always_comb begin
        aw_hold_d = aw_hold_q;
        if (w_aw_hs) begin
            aw_hold_d = 1'b0;
        end else if (cmd_out_valid) begin
            aw_hold_d = 1'b1;
        end
    end

    // Accept and return may coincide; both are folded into one update, and
    // a return larger than the running total clamps to zero and flags it.
    assign w_sum = {1'b0, os_cnt_q} + (w_aw_hs ? beats(cmd_in_len) : '0);
    assign w_ret = eg2ig_axi_vld ? beats(eg2ig_axi_len) : '0;

    always_comb begin
        os_cnt_d = OS_CNT_W'(w_sum - w_ret);
        os_err_d = os_err_q;
        if (w_ret > w_sum) begin
            os_cnt_d = '0;
            os_err_d = 1'b1;
        end
    end

    // ---------------- data side ----------------
    assign dat_out_valid = dat_in_valid & ~w_empty;
    assign dat_in_ready  = dat_out_ready & ~w_empty;
    assign dat_out_last  = ~w_empty & (beat_cnt_q == w_head);
    assign w_dat_hs      = dat_in_valid & dat_out_ready & ~w_empty;
    assign w_pop         = w_dat_hs & dat_out_last;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (w_dat_hs) begin
            beat_cnt_d = dat_out_last ? '0 : beat_cnt_q + LEN_W'(1);
        end
    end

    mcif_write_len_fifo #(
        .WIDTH (LEN_W),
        .DEPTH (LFIFO_DEPTH)
    ) u_len_fifo (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .push_i  (w_aw_hs),
        .data_i  (cmd_in_len),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            os_cnt_q   <= '0;
            os_err_q   <= 1'b0;
            aw_hold_q  <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            os_cnt_q   <= os_cnt_d;
            os_err_q   <= os_err_d;
            aw_hold_q  <= aw_hold_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign os_cnt_cur = os_cnt_q;
    assign os_err     = os_err_q;

endmodule : mcif_write_os_ctrl
`default_nettype wire

// File: tb/tb_mcif_write_os_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcif_write_os_ctrl
// Description : Self-checking bench for mcif_write_os_ctrl: directed
//               scenarios plus randomized traffic against a queue-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcif_write_os_ctrl;

    logic       nvdla_core_clk = 1'b0;
    logic       nvdla_core_rstn;
    logic [7:0] reg2dp_wr_os_cnt;
    logic       cmd_in_valid, cmd_in_ready;
    logic [1:0] cmd_in_len;
    logic       cmd_out_valid, cmd_out_ready;
    logic       dat_in_valid, dat_in_ready;
    logic       dat_out_valid, dat_out_ready, dat_out_last;
    logic       eg2ig_axi_vld;
    logic [1:0] eg2ig_axi_len;
    logic [8:0] os_cnt_cur;
    logic       os_err;

    int total = 0;
    int bad   = 0;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    mcif_write_os_ctrl dut (
        .nvdla_core_clk   (nvdla_core_clk),
        .nvdla_core_rstn  (nvdla_core_rstn),
        .reg2dp_wr_os_cnt (reg2dp_wr_os_cnt),
        .cmd_in_valid     (cmd_in_valid),
        .cmd_in_ready     (cmd_in_ready),
        .cmd_in_len       (cmd_in_len),
        .cmd_out_valid    (cmd_out_valid),
        .cmd_out_ready    (cmd_out_ready),
        .dat_in_valid     (dat_in_valid),
        .dat_in_ready     (dat_in_ready),
        .dat_out_valid    (dat_out_valid),
        .dat_out_ready    (dat_out_ready),
        .dat_out_last     (dat_out_last),
        .eg2ig_axi_vld    (eg2ig_axi_vld),
        .eg2ig_axi_len    (eg2ig_axi_len),
        .os_cnt_cur       (os_cnt_cur),
        .os_err           (os_err)
    );

    // ---------------- reference model ----------------
    // Commands awaiting data are a queue of lengths; budget is a plain int.
    int m_os;
    bit m_err;
    bit m_hold;
    int m_beat;
    int m_q[$];
    bit e_cov, e_cir, e_dov, e_dir, e_last;

    task automatic model_reset();
        m_os = 0; m_err = 0; m_hold = 0; m_beat = 0; m_q.delete();
    endtask

    task automatic model_eval();
        bit credit, full, have;
        credit = (m_os + int'(cmd_in_len) + 1) <= (int'(reg2dp_wr_os_cnt) + 1);
        full   = (m_q.size() >= 4);
        have   = (m_q.size() > 0);
        e_cov  = cmd_in_valid && ((credit && !full) || m_hold);
        e_cir  = e_cov && cmd_out_ready;
        e_dov  = dat_in_valid && have;
        e_dir  = dat_out_ready && have;
        e_last = have && (m_beat == m_q[0]);
    endtask

    task automatic model_update();
        int sum, r;
        if (e_dov && dat_out_ready) begin
            if (e_last) begin
                void'(m_q.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        sum = m_os;
        if (e_cir) begin
            m_q.push_back(int'(cmd_in_len));
            sum += int'(cmd_in_len) + 1;
            m_hold = 0;
        end else if (e_cov) begin
            m_hold = 1;
        end
        if (eg2ig_axi_vld) begin
            r = int'(eg2ig_axi_len) + 1;
            if (r > sum) begin
                m_os = 0; m_err = 1;
            end else begin
                m_os = sum - r;
            end
        end else begin
            m_os = sum;
        end
    endtask

    // Inputs are driven just after negedge; outputs are sampled 1ns later.
    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge nvdla_core_clk);
        model_update();
        @(negedge nvdla_core_clk);
    endtask

    task automatic idle_inputs();
        cmd_in_valid = 0; cmd_in_len = 0; cmd_out_ready = 0;
        dat_in_valid = 0; dat_out_ready = 0;
        eg2ig_axi_vld = 0; eg2ig_axi_len = 0;
    endtask

    task automatic do_reset();
        nvdla_core_rstn = 0;
        idle_inputs();
        reg2dp_wr_os_cnt = 8'd7;
        model_reset();
        @(negedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset();
        dat_in_valid = 1; dat_out_ready = 1;
        settle();
        total++; if (os_cnt_cur !== 9'd0) begin bad++; $display("FAIL reset_os: got %0d want 0", os_cnt_cur); end
        total++; if (os_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", os_err); end
        total++; if (dat_out_valid !== 1'b0 || dat_in_ready !== 1'b0) begin bad++; $display("FAIL reset_dat: got v=%b r=%b want 0 0", dat_out_valid, dat_in_ready); end
        total++; if (dat_out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", dat_out_last); end
        total++; if (cmd_out_valid !== 1'b0) begin bad++; $display("FAIL reset_cov: got %b want 0", cmd_out_valid); end
        idle_inputs();
    endtask

    task automatic test_credit();
        do_reset();
        cmd_out_ready = 1; cmd_in_valid = 1; cmd_in_len = 3;
        settle();
        total++; if (cmd_in_ready !== 1'b1) begin bad++; $display("FAIL credit_first: got %b want 1", cmd_in_ready); end
        tick(); settle();
        total++; if (cmd_in_ready !== 1'b1) begin bad++; $display("FAIL credit_second: got %b want 1", cmd_in_ready); end
        tick();
        cmd_in_len = 0; settle();
        total++; if (cmd_in_ready !== 1'b0 || os_cnt_cur !== 9'd8) begin bad++; $display("FAIL credit_stall: got rdy=%b os=%0d want 0 8", cmd_in_ready, os_cnt_cur); end
        tick();
        eg2ig_axi_vld = 1; eg2ig_axi_len = 3; settle();
        total++; if (cmd_in_ready !== 1'b0) begin bad++; $display("FAIL credit_ret_cycle: got %b want 0", cmd_in_ready); end
        tick();
        eg2ig_axi_vld = 0; settle();
        total++; if (cmd_in_ready !== 1'b1 || os_cnt_cur !== 9'd4) begin bad++; $display("FAIL credit_resume: got rdy=%b os=%0d want 1 4", cmd_in_ready, os_cnt_cur); end
        tick();
        cmd_in_valid = 0; settle();
        total++; if (os_cnt_cur !== 9'd5) begin bad++; $display("FAIL credit_final_os: got %0d want 5", os_cnt_cur); end
        idle_inputs();
    endtask

    task automatic test_data_gating();
        do_reset();
        dat_in_valid = 1; dat_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            total++; if (dat_out_valid !== 1'b0 || dat_in_ready !== 1'b0) begin bad++; $display("FAIL gate_early%0d: got v=%b r=%b want 0 0", i, dat_out_valid, dat_in_ready); end
            tick();
        end
        cmd_in_valid = 1; cmd_in_len = 1; cmd_out_ready = 1; settle();
        total++; if (cmd_in_ready !== 1'b1 || dat_out_valid !== 1'b0) begin bad++; $display("FAIL gate_same_cycle: got rdy=%b dv=%b want 1 0", cmd_in_ready, dat_out_valid); end
        tick();
        cmd_in_valid = 0; settle();
        total++; if (dat_out_valid !== 1'b1 || dat_out_last !== 1'b0) begin bad++; $display("FAIL gate_beat0: got v=%b l=%b want 1 0", dat_out_valid, dat_out_last); end
        tick(); settle();
        total++; if (dat_out_valid !== 1'b1 || dat_out_last !== 1'b1) begin bad++; $display("FAIL gate_beat1: got v=%b l=%b want 1 1", dat_out_valid, dat_out_last); end
        tick(); settle();
        total++; if (dat_out_valid !== 1'b0) begin bad++; $display("FAIL gate_drained: got %b want 0", dat_out_valid); end
        idle_inputs();
    endtask

    task automatic test_stall_stability();
        do_reset();
        cmd_in_valid = 1; cmd_in_len = 3; cmd_out_ready = 0; settle();
        total++; if (cmd_out_valid !== 1'b1 || cmd_in_ready !== 1'b0) begin bad++; $display("FAIL stall_start: got v=%b r=%b want 1 0", cmd_out_valid, cmd_in_ready); end
        tick();
        reg2dp_wr_os_cnt = 8'd0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (cmd_out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d: got %b want 1", i, cmd_out_valid); end
            tick();
        end
        cmd_out_ready = 1; settle();
        total++; if (cmd_in_ready !== 1'b1) begin bad++; $display("FAIL stall_accept: got %b want 1", cmd_in_ready); end
        tick();
        cmd_in_len = 0; settle();
        total++; if (os_cnt_cur !== 9'd4 || cmd_out_valid !== 1'b0) begin bad++; $display("FAIL stall_after: got os=%0d v=%b want 4 0", os_cnt_cur, cmd_out_valid); end
        tick();
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        reg2dp_wr_os_cnt = 8'd255;
        cmd_in_valid = 1; cmd_in_len = 0; cmd_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++; if (cmd_in_ready !== 1'b1) begin bad++; $display("FAIL full_fill%0d: got %b want 1", i, cmd_in_ready); end
            tick();
        end
        settle();
        total++; if (cmd_out_valid !== 1'b0 || os_cnt_cur !== 9'd4) begin bad++; $display("FAIL full_block: got v=%b os=%0d want 0 4", cmd_out_valid, os_cnt_cur); end
        dat_in_valid = 1; dat_out_ready = 1; settle();
        total++; if (dat_in_ready !== 1'b1 || cmd_in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_cycle: got dr=%b cr=%b want 1 0", dat_in_ready, cmd_in_ready); end
        tick();
        dat_in_valid = 0; settle();
        total++; if (cmd_in_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop: got %b want 1", cmd_in_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        cmd_in_valid = 1; cmd_in_len = 3; cmd_out_ready = 1; settle(); tick();
        cmd_in_len = 2; eg2ig_axi_vld = 1; eg2ig_axi_len = 1; settle();
        total++; if (cmd_in_ready !== 1'b1 || os_cnt_cur !== 9'd4) begin bad++; $display("FAIL simul_pre: got rdy=%b os=%0d want 1 4", cmd_in_ready, os_cnt_cur); end
        tick();
        cmd_in_valid = 0; eg2ig_axi_vld = 0; settle();
        total++; if (os_cnt_cur !== 9'd5) begin bad++; $display("FAIL simul_net: got %0d want 5", os_cnt_cur); end
        idle_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        cmd_in_valid = 1; cmd_in_len = 0; cmd_out_ready = 1; settle(); tick();
        cmd_in_valid = 0; settle();
        total++; if (os_cnt_cur !== 9'd1) begin bad++; $display("FAIL uflow_pre: got %0d want 1", os_cnt_cur); end
        eg2ig_axi_vld = 1; eg2ig_axi_len = 3; settle(); tick();
        eg2ig_axi_vld = 0; settle();
        total++; if (os_cnt_cur !== 9'd0 || os_err !== 1'b1) begin bad++; $display("FAIL uflow_clamp: got os=%0d err=%b want 0 1", os_cnt_cur, os_err); end
        tick(); tick(); settle();
        total++; if (os_err !== 1'b1) begin bad++; $display("FAIL uflow_sticky: got %b want 1", os_err); end
        dat_in_valid = 1;
        #3 nvdla_core_rstn = 0;
        #1;
        total++; if (os_err !== 1'b0 || os_cnt_cur !== 9'd0 || dat_out_valid !== 1'b0) begin bad++; $display("FAIL uflow_async_rst: got err=%b os=%0d dv=%b want 0 0 0", os_err, os_cnt_cur, dat_out_valid); end
        model_reset();
        idle_inputs();
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1;
    endtask

    // ---------------- randomized traffic ----------------
    task automatic test_random();
        int flight[$];
        bit acc;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 100 == 0) begin
                case ($urandom_range(0, 4))
                    0: reg2dp_wr_os_cnt = 8'd0;
                    1: reg2dp_wr_os_cnt = 8'd3;
                    2: reg2dp_wr_os_cnt = 8'd7;
                    3: reg2dp_wr_os_cnt = 8'd255;
                    default: reg2dp_wr_os_cnt = 8'($urandom_range(0, 255));
                endcase
            end
            if (!cmd_in_valid && ($urandom_range(0, 2) == 0)) begin
                cmd_in_valid = 1;
                cmd_in_len   = 2'($urandom_range(0, 3));
            end
            cmd_out_ready = ($urandom_range(0, 3) != 0);
            dat_in_valid  = ($urandom_range(0, 9) < 7);
            dat_out_ready = ($urandom_range(0, 9) < 7);
            if (flight.size() > 0 && $urandom_range(0, 2) == 0) begin
                eg2ig_axi_vld = 1;
                eg2ig_axi_len = 2'(flight.pop_front());
            end else begin
                eg2ig_axi_vld = 0;
            end
            settle();
            total++; if (cmd_out_valid !== e_cov) begin bad++; $display("FAIL rnd_cov@%0d: got %b want %b", cyc, cmd_out_valid, e_cov); end
            total++; if (cmd_in_ready !== e_cir) begin bad++; $display("FAIL rnd_cir@%0d: got %b want %b", cyc, cmd_in_ready, e_cir); end
            total++; if (dat_out_valid !== e_dov) begin bad++; $display("FAIL rnd_dov@%0d: got %b want %b", cyc, dat_out_valid, e_dov); end
            total++; if (dat_in_ready !== e_dir) begin bad++; $display("FAIL rnd_dir@%0d: got %b want %b", cyc, dat_in_ready, e_dir); end
            total++; if (dat_out_last !== e_last) begin bad++; $display("FAIL rnd_last@%0d: got %b want %b", cyc, dat_out_last, e_last); end
            total++; if (int'(os_cnt_cur) != m_os) begin bad++; $display("FAIL rnd_os@%0d: got %0d want %0d", cyc, os_cnt_cur, m_os); end
            total++; if (os_err !== m_err) begin bad++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, os_err, m_err); end
            acc = e_cir;
            if (acc) flight.push_back(int'(cmd_in_len));
            tick();
            if (acc) cmd_in_valid = 0;
        end
        idle_inputs();
    endtask

    initial begin
        nvdla_core_rstn  = 0;
        reg2dp_wr_os_cnt = 8'd7;
        idle_inputs();
        model_reset();
        @(negedge nvdla_core_clk);
        test_reset();
        test_credit();
        test_data_gating();
        test_stall_stability();
        test_fifo_full();
        test_simultaneous();
        test_underflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mcif_write_os_ctrl
`default_nettype wire
